// File: rtl/blocking_out_arbiter.sv
// Round-robin arbiter sharing one registered notify/sync output channel among N producers.
// A grant loads the selected word into the output register; the consumer's sync frees it.
module blocking_out_arbiter #(
   parameter  int N      = 4,
   parameter  int DATA_W = 32,
   localparam int IDX_W  = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_notify,
   input  logic [N*DATA_W-1:0]   req_data,
   output logic [N-1:0]          req_sync,
   output logic [DATA_W-1:0]     b_out,
   output logic                  b_out_notify,
   input  logic                  b_out_sync,
   output logic [IDX_W-1:0]      b_out_src,
   output logic [15:0]           xfer_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [DATA_W-1:0]   b_out_q, b_out_d;
   logic [IDX_W-1:0]    src_q, src_d;
   logic                vld_q, vld_d;
   logic [15:0]         cnt_q, cnt_d;

   logic [IDX_W-1:0]    sel_s;
   logic                found_s;
   logic                any_req_s;
   logic                load_s;

   // Index base+off reduced modulo N; off is always below N.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N) begin
         sum = sum - N;
      end else begin
         sum = sum;
      end
      return IDX_W'(sum);
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
      return {{(N-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Round-robin search from the pointer for the first requester offering a word.
   always_comb begin
      sel_s   = ptr_q;
      found_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found_s && req_notify[wrap_add(ptr_q, k)]) begin
            sel_s   = wrap_add(ptr_q, k);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_req_s = |req_notify;

   // Load decision; suppressed during reset so no requester believes its word was taken.
   always_comb begin
      load_s = 1'b0;
      case (state_q)
         ST_IDLE: load_s = any_req_s;
         ST_SEND: load_s = b_out_sync & any_req_s;
         default: load_s = 1'b0;
      endcase
      load_s = load_s & rst;
   end

   // Next-state, output-register and pointer update.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      b_out_d = b_out_q;
      src_d   = src_q;
      vld_d   = vld_q;
      cnt_d   = (vld_q && b_out_sync) ? cnt_q + 16'd1 : cnt_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_SEND: begin
            if (b_out_sync) begin
               state_d = ST_IDLE;
               vld_d   = 1'b0;
            end else begin
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
         end
      endcase
      if (load_s) begin
         state_d = ST_SEND;
         vld_d   = 1'b1;
         b_out_d = req_data[sel_s*DATA_W +: DATA_W];
         src_d   = sel_s;
         ptr_d   = (sel_s == IDX_W'(N-1)) ? '0 : sel_s + IDX_W'(1);
      end else begin
         ptr_d   = ptr_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         b_out_q <= '0;
         src_q   <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         b_out_q <= b_out_d;
         src_q   <= src_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_sync     = load_s ? onehot(sel_s) : '0;
   assign b_out        = b_out_q;
   assign b_out_src    = src_q;
   assign b_out_notify = vld_q;
   assign xfer_cnt     = cnt_q;

endmodule

// File: tb/tb_blocking_out_arbiter.sv
// Directed bench for blocking_out_arbiter (N=4): a vector table for the steady-state
// behaviour plus hand-written reset, reset-mid-send and counter-wrap sequences.
module tb_blocking_out_arbiter;

   localparam int N      = 4;
   localparam int DATA_W = 32;
   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_1111;
   localparam logic [31:0] D2 = 32'h0000_00A5;
   localparam logic [31:0] D3 = 32'h4444_3333;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         req_notify;
   logic [N*DATA_W-1:0]  req_data;
   logic [N-1:0]         req_sync;
   logic [DATA_W-1:0]    b_out;
   logic                 b_out_notify;
   logic                 b_out_sync;
   logic [1:0]           b_out_src;
   logic [15:0]          xfer_cnt;

   int n_checks;
   int n_fail;

   blocking_out_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_notify   (req_notify),
      .req_data     (req_data),
      .req_sync     (req_sync),
      .b_out        (b_out),
      .b_out_notify (b_out_notify),
      .b_out_sync   (b_out_sync),
      .b_out_src    (b_out_src),
      .xfer_cnt     (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  notify;
      logic        sync;
      logic [3:0]  exp_rs;
      logic [31:0] exp_bout;
      logic        exp_vld;
      logic [1:0]  exp_src;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic [3:0] nt, input logic sy, input logic [3:0] rs,
                               input logic [31:0] bo, input logic vl, input logic [1:0] sr,
                               input logic [15:0] cn);
      vec_t v;
      v.notify = nt; v.sync = sy; v.exp_rs = rs; v.exp_bout = bo;
      v.exp_vld = vl; v.exp_src = sr; v.exp_cnt = cn;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b0;
      req_notify = 4'b0000;
      b_out_sync = 1'b0;
      req_data   = {D3, D2, D1, D0};

      // single requester, then backpressure with another requester waiting
      vecs[0]  = mk(4'b0100, 1'b0, 4'b0100, D2, 1'b1, 2'd2, 16'd0);
      for (int i = 1; i <= 5; i++)
         vecs[i] = mk(4'b0001, 1'b0, 4'b0000, D2, 1'b1, 2'd2, 16'd0);
      vecs[6]  = mk(4'b1000, 1'b1, 4'b1000, D3, 1'b1, 2'd3, 16'd1);
      // full contention from pointer 0
      vecs[7]  = mk(4'b1111, 1'b1, 4'b0001, D0, 1'b1, 2'd0, 16'd2);
      vecs[8]  = mk(4'b1111, 1'b1, 4'b0010, D1, 1'b1, 2'd1, 16'd3);
      vecs[9]  = mk(4'b1111, 1'b1, 4'b0100, D2, 1'b1, 2'd2, 16'd4);
      vecs[10] = mk(4'b1111, 1'b1, 4'b1000, D3, 1'b1, 2'd3, 16'd5);
      vecs[11] = mk(4'b1111, 1'b1, 4'b0001, D0, 1'b1, 2'd0, 16'd6);
      vecs[12] = mk(4'b1111, 1'b1, 4'b0010, D1, 1'b1, 2'd1, 16'd7);
      // pointer wrap: grant 3, then 0 ahead of 3, then 3
      vecs[13] = mk(4'b1000, 1'b1, 4'b1000, D3, 1'b1, 2'd3, 16'd8);
      vecs[14] = mk(4'b1001, 1'b1, 4'b0001, D0, 1'b1, 2'd0, 16'd9);
      vecs[15] = mk(4'b1000, 1'b1, 4'b1000, D3, 1'b1, 2'd3, 16'd10);
      // drain to idle, then sync while idle is ignored
      vecs[16] = mk(4'b0000, 1'b1, 4'b0000, D3, 1'b0, 2'd3, 16'd11);
      vecs[17] = mk(4'b0000, 1'b1, 4'b0000, D3, 1'b0, 2'd3, 16'd11);
      vecs[18] = mk(4'b0000, 1'b0, 4'b0000, D3, 1'b0, 2'd3, 16'd11);

      // Reset values, observed before any clock edge
      #($urandom_range(1, 3));
      check("reset b_out",        b_out,               32'h0);
      check("reset b_out_notify", 32'(b_out_notify),   32'h0);
      check("reset b_out_src",    32'(b_out_src),      32'h0);
      check("reset xfer_cnt",     32'(xfer_cnt),       32'h0);
      check("reset req_sync",     32'(req_sync),       32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 19; i++) begin
         req_notify = vecs[i].notify;
         b_out_sync = vecs[i].sync;
         #2;
         check($sformatf("v%0d req_sync", i), 32'(req_sync), 32'(vecs[i].exp_rs));
         @(posedge clk);
         #1;
         check($sformatf("v%0d b_out", i),        b_out,              vecs[i].exp_bout);
         check($sformatf("v%0d b_out_notify", i), 32'(b_out_notify),  32'(vecs[i].exp_vld));
         check($sformatf("v%0d b_out_src", i),    32'(b_out_src),     32'(vecs[i].exp_src));
         check($sformatf("v%0d xfer_cnt", i),     32'(xfer_cnt),      32'(vecs[i].exp_cnt));
      end

      // Reset while a word is held in st_send, with a requester still notifying
      req_notify = 4'b0010;
      b_out_sync = 1'b0;
      @(posedge clk);
      #1;
      check("pre-reset b_out_notify", 32'(b_out_notify), 32'h1);
      check("pre-reset b_out",        b_out,             D1);
      req_notify = 4'b0010;
      #2;
      rst = 1'b0;
      #1;
      check("midreset b_out_notify", 32'(b_out_notify), 32'h0);
      check("midreset b_out",        b_out,             32'h0);
      check("midreset req_sync",     32'(req_sync),     32'h0);
      check("midreset xfer_cnt",     32'(xfer_cnt),     32'h0);

      // Counter wrap: one transfer per cycle after the first load
      req_notify = 4'b0001;
      b_out_sync = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (65536) @(posedge clk);
      #1;
      check("cnt at ffff",        32'(xfer_cnt),     32'h0000_FFFF);
      check("cnt b_out_notify",   32'(b_out_notify), 32'h1);
      @(posedge clk);
      #1;
      check("cnt wrap",           32'(xfer_cnt),     32'h0);
      check("cnt wrap b_out",     b_out,             D0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/blocking_out_arbiter.md
# blocking_out_arbiter

Round-robin arbiter that shares one blocking output channel (notify/sync handshake, as used by the generated block skeletons) among `N` producer sections. Each producer offers a word with its own notify/sync pair. The arbiter grants one producer at a time, registers the word and presents it on the shared `b_out` channel until the consumer syncs. It sits between the producer modules and the single consumer of the shared port.

## Interface
Parameters:
- `N`, 4, number of requesters; legal range 2..16.
- `DATA_W`, 32, width of the flattened compound word.
- `IDX_W`, $clog2(N), derived localparam; not overridable.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_notify`  in  N  bit i: requester i offers `req_data[i]`.
- `req_data`  in  N*DATA_W  word of requester i in bits [i*DATA_W +: DATA_W].
- `req_sync`  out  N  one-hot or zero; bit i high means requester i's word is taken at this edge.
- `b_out`  out  DATA_W  registered word on the shared channel.
- `b_out_notify`  out  1  `b_out` holds a valid word.
- `b_out_sync`  in  1  consumer accepts `b_out` at this edge.
- `b_out_src`  out  IDX_W  index of the requester that supplied `b_out`.
- `xfer_cnt`  out  16  count of words delivered to the consumer; wraps.

## Operation
- **Transfer rule (both sides).** A word moves at a rising edge where notify and sync are both high in that cycle.
- **Requester obligations.** Hold `req_notify[i]` and `req_data[i]` stable until `req_sync[i]`. Withdrawing notify before a grant is legal.
- **Grant pointer.** `ptr` is IDX_W bits, reset 0. It names the highest-priority requester.
- **Selection.** Search `req_notify` from `ptr` upward, modulo N. The first set bit is `sel`.
- **Pointer update.** On each accepted requester word: `ptr <= (sel == N-1) ? 0 : sel+1`.
- **FSM states.**
  - `st_idle`: no valid word.
  - `st_send`: `b_out` valid.
- **Load enable.**
  - In `st_idle`: `load = |req_notify`.
  - In `st_send`: `load = b_out_sync & |req_notify`.
- **req_sync.** `req_sync = load ? onehot(sel) : 0`. This path is combinational. It is never asserted for a requester whose notify is low.
- **On load:**
  - `b_out <= req_data[sel]`
  - `b_out_src <= sel`
  - `b_out_notify <= 1`
  - state `<= st_send`
- **In st_send with b_out_sync=1 and no request:** `b_out_notify <= 0`, state `<= st_idle`. `b_out` and `b_out_src` keep their old values.
- **In st_send with b_out_sync=0:** everything holds and `req_sync = 0`.
- **`b_out_sync` while in st_idle:** ignored.
- **xfer_cnt:** increments by 1 on every edge with `b_out_notify & b_out_sync`. It wraps 0xFFFF→0x0000.
- **Reset values (asynchronous, while rst=0):**
  - state `st_idle`, `ptr` 0
  - `b_out` 0, `b_out_src` 0
  - `b_out_notify` 0, `xfer_cnt` 0
  - hence `req_sync` 0
- **Reset mid-operation.** A word held in `st_send` is discarded. No sync is issued for it, and the requester's original transfer already completed.

## Timing
- Grant latency: `req_sync` is asserted in the same cycle as `req_notify` when the arbiter can load.
- `b_out_notify` rises on the edge after the grant. That is 1 cycle from request to channel-valid with no contention.
- Throughput: one word per cycle while the consumer holds `b_out_sync` high and requests are pending. There are no bubbles on back-to-back loads.
- Backpressure: `b_out` is stable for as long as `b_out_sync` is low.
- Worst-case wait for a continuously requesting producer: N-1 grants ahead of it.
- Combinational paths:
  - `b_out_sync` → `req_sync`
  - `req_notify` → `req_sync`
  - No other input-to-output combinational paths.

## Test plan
1. **Reset values.** Assert rst=0 at a random point, then release. Required: all outputs 0, `req_sync` = 0, before the next clock edge.
2. **Single requester, N=4.** `req_notify`=0b0100, `req_data[2]`=0x000000A5, `b_out_sync`=0.
   - Same cycle: `req_sync`=0b0100.
   - Next cycle: `b_out`=0xA5, `b_out_src`=2, `b_out_notify`=1.
   - Hold `b_out_sync`=0 for 5 cycles: outputs stable, `req_sync`=0.
3. **Full contention.** All four requesting continuously, `b_out_sync`=1 throughout.
   - Grant order 0,1,2,3,0,1.
   - One word per cycle on `b_out`.
   - `xfer_cnt` increments every cycle after the first.
4. **Pointer wrap.** Last grant was 3, then `req_notify`=0b1001. Required: grant 0 then 3 (`req_sync`=0b0001, then 0b1000).
5. **Drain to idle.** One word in `st_send`, no requests, `b_out_sync`=1 for one cycle. Required:
   - `b_out_notify` 0 next cycle and `b_out` retains its value.
   - Then `b_out_sync`=1 while idle: `xfer_cnt` unchanged.
6. **Reset mid-send, then counter wrap.**
   - Reset in `st_send`: `b_out_notify` drops immediately, no `req_sync`.
   - Preload `xfer_cnt` to 0xFFFF via 65535 transfers (or force), then one more transfer: required `xfer_cnt`=0x0000.
